// File: rtl/cordic_round_sat.sv
// Multi-channel round/saturate stage: IW-bit signed samples to OW bits, 2-stage pipeline.
// Optional saturation event counter enabled by defining CORDIC_ROUND_OVF_CNT_EN.
module cordic_round_sat #(
    parameter int unsigned NCH = 2,
    parameter int unsigned IW  = 16,
    parameter int unsigned OW  = 13
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    input  logic                i_valid,
    input  logic [1:0]          i_mode,
    input  logic [NCH*IW-1:0]   i_data,
    input  logic                i_clr_ovf,
    output logic                o_valid,
    output logic [NCH*OW-1:0]   o_data,
`ifdef CORDIC_ROUND_OVF_CNT_EN
    output logic [15:0]         o_ovf_cnt,
`endif
    output logic [NCH-1:0]      o_ovf
);

    localparam int unsigned D  = IW - OW;
    localparam int unsigned RW = OW + 1;
    localparam int unsigned SW = IW + 1;
    localparam logic [SW-1:0] HALF = SW'(1) << (D - 1);
    localparam logic [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

    logic [NCH*RW-1:0] s1_r;
    logic              s1_valid;
    logic [NCH*RW-1:0] rnd_c;
    logic [NCH*OW-1:0] sat_data_c;
    logic [NCH-1:0]    sat_c;
    logic              ovf_hit_c;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [SW-1:0] x;
        logic [SW-1:0] add;
        logic [SW-1:0] s;
        logic [D-1:0]  unused_frac;
        logic [RW-1:0] r;

        // Rounding constant chosen per mode; the sum keeps one guard bit above IW.
        always_comb begin
            x   = {i_data[k*IW + IW - 1], i_data[k*IW +: IW]};
            add = '0;
            case (i_mode)
                2'd1:    add = HALF;
                2'd2:    add = HALF - SW'(1) + SW'(x[D]);
                2'd3:    add = x[SW-1] ? (HALF - SW'(1)) : HALF;
                default: add = '0;
            endcase
            s = x + add;
        end

        assign rnd_c[k*RW +: RW] = s[IW:D];
        assign unused_frac       = s[D-1:0];

        // Clamp when the guard bit disagrees with the output sign bit.
        assign r        = s1_r[k*RW +: RW];
        assign sat_c[k] = r[OW] ^ r[OW-1];
        assign sat_data_c[k*OW +: OW] = sat_c[k] ? (r[OW] ? MIN_V : MAX_V) : r[OW-1:0];
    end

    assign ovf_hit_c = i_ce & s1_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_r     <= '0;
            s1_valid <= 1'b0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_ovf    <= '0;
        end else begin
            if (i_ce) begin
                s1_r     <= rnd_c;
                s1_valid <= i_valid;
                o_data   <= sat_data_c;
                o_valid  <= s1_valid;
            end
            // Clear is independent of i_ce; a same-cycle set wins.
            o_ovf <= (i_clr_ovf ? '0 : o_ovf) | ({NCH{ovf_hit_c}} & sat_c);
        end
    end

`ifdef CORDIC_ROUND_OVF_CNT_EN
    logic cnt_inc_c;
    assign cnt_inc_c = ovf_hit_c & (|sat_c);

    // Saturating event counter; an increment overrides a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ovf_cnt <= '0;
        end else if (cnt_inc_c) begin
            if (i_clr_ovf)
                o_ovf_cnt <= 16'd1;
            else if (o_ovf_cnt != 16'hFFFF)
                o_ovf_cnt <= o_ovf_cnt + 16'd1;
        end else if (i_clr_ovf) begin
            o_ovf_cnt <= '0;
        end
    end
`endif

endmodule
